// File: rtl/delayed_write_fifo_ptrs.sv
// Pointer/status engine for a dataless show-ahead FIFO with a delayed write request
// and an equally delayed almost-full return path. Optional sticky flags: FIFO_PTRS_DEBUG_FLAGS_EN.
module delayed_write_fifo_ptrs #(
  parameter int  DEPTH               = 16,
  parameter int  WRITE_DELAY         = 0,
  parameter int  ALMOST_FULL_MARGIN  = 0,
  parameter int  ALMOST_EMPTY_MARGIN = 0,
  localparam int LOG_DEPTH           = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 wrreq,
  output logic                 full,
  input  logic                 rdreq,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [LOG_DEPTH:0]   usedw,
  output logic [LOG_DEPTH-1:0] wrptr,
  output logic [LOG_DEPTH-1:0] rdptr,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AF_INT = ALMOST_FULL_MARGIN + 2 * WRITE_DELAY;

  localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH:0]   CNT_MAX  = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   AE_LEVEL = (LOG_DEPTH + 1)'(ALMOST_EMPTY_MARGIN);
  localparam logic [LOG_DEPTH:0]   AF_LEVEL = (LOG_DEPTH + 1)'(DEPTH - AF_INT);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

  if (AF_INT >= DEPTH) begin : g_margin_check
    $error("ALMOST_FULL_MARGIN + 2*WRITE_DELAY (%0d) must be below DEPTH (%0d)", AF_INT, DEPTH);
  end

  logic                 wr_d;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [LOG_DEPTH:0]   usedw_q, usedw_d;
  logic [LOG_DEPTH-1:0] wrptr_q, wrptr_d;
  logic [LOG_DEPTH-1:0] rdptr_q, rdptr_d;
  logic                 empty_q;
  logic                 almost_empty_q;
  logic                 af_q;

  // Delay chains prepend the live input so a single slice works for any WRITE_DELAY >= 1.
  if (WRITE_DELAY == 0) begin : g_wr_direct
    assign wr_d = wrreq;
  end else begin : g_wr_pipe
    logic [WRITE_DELAY-1:0] wr_pipe_q;
    logic [WRITE_DELAY:0]   wr_chain;
    assign wr_chain = {wr_pipe_q, wrreq};
    always_ff @(posedge clock) begin
      if (rst) wr_pipe_q <= '0;
      else     wr_pipe_q <= wr_chain[WRITE_DELAY-1:0];
    end
    assign wr_d = wr_pipe_q[WRITE_DELAY-1];
  end

  always_comb begin
    wr_ok   = wr_d && (usedw_q != CNT_MAX);
    rd_ok   = rdreq && (usedw_q != '0);
    usedw_d = usedw_q;
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    if (wr_ok) wrptr_d = wrptr_q + PTR_ONE;
    if (rd_ok) rdptr_d = rdptr_q + PTR_ONE;
    if (wr_ok && !rd_ok)      usedw_d = usedw_q + CNT_ONE;
    else if (rd_ok && !wr_ok) usedw_d = usedw_q - CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      usedw_q        <= '0;
      wrptr_q        <= '0;
      rdptr_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      af_q           <= 1'b1;
    end else begin
      usedw_q        <= usedw_d;
      wrptr_q        <= wrptr_d;
      rdptr_q        <= rdptr_d;
      empty_q        <= (usedw_d == '0);
      almost_empty_q <= (usedw_d <= AE_LEVEL);
      af_q           <= (usedw_d >= AF_LEVEL);
    end
  end

  if (WRITE_DELAY == 0) begin : g_full_direct
    assign full = af_q;
  end else begin : g_full_pipe
    logic [WRITE_DELAY-1:0] full_pipe_q;
    logic [WRITE_DELAY:0]   full_chain;
    assign full_chain = {full_pipe_q, af_q};
    always_ff @(posedge clock) begin
      if (rst) full_pipe_q <= '1;
      else     full_pipe_q <= full_chain[WRITE_DELAY-1:0];
    end
    assign full = full_pipe_q[WRITE_DELAY-1];
  end

`ifdef FIFO_PTRS_DEBUG_FLAGS_EN
  logic overflow_q;
  logic underflow_q;
  always_ff @(posedge clock) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_d && !wr_ok)  overflow_q  <= 1'b1;
      if (rdreq && !rd_ok) underflow_q <= 1'b1;
    end
  end
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign usedw        = usedw_q;
  assign wrptr        = wrptr_q;
  assign rdptr        = rdptr_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;

endmodule

// File: tb/tb_delayed_write_fifo_ptrs.sv
// Bench for delayed_write_fifo_ptrs: instance A (WRITE_DELAY=2) and instance B (WRITE_DELAY=0),
// checked against a queue-based occupancy model plus fixed scenario expectations.
module tb_delayed_write_fifo_ptrs;

  localparam int DEPTH = 16;
  localparam int WD_A  = 2;
  localparam int WD_B  = 0;
  localparam int AEM_A = 2;
  localparam int AEM_B = 0;
`ifdef FIFO_PTRS_DEBUG_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_wrreq = 1'b0, a_rdreq = 1'b0;
  logic       a_full, a_empty, a_aempty, a_ovf, a_unf;
  logic [4:0] a_usedw;
  logic [3:0] a_wrptr, a_rdptr;

  logic       b_rst = 1'b1, b_wrreq = 1'b0, b_rdreq = 1'b0;
  logic       b_full, b_empty, b_aempty, b_ovf, b_unf;
  logic [4:0] b_usedw;
  logic [3:0] b_wrptr, b_rdptr;

  int errors = 0;
  int checks = 0;

  delayed_write_fifo_ptrs #(.DEPTH(DEPTH), .WRITE_DELAY(WD_A), .ALMOST_FULL_MARGIN(0),
                            .ALMOST_EMPTY_MARGIN(AEM_A)) dut_a (
    .clock(clk), .rst(a_rst), .wrreq(a_wrreq), .full(a_full), .rdreq(a_rdreq),
    .empty(a_empty), .almost_empty(a_aempty), .usedw(a_usedw), .wrptr(a_wrptr),
    .rdptr(a_rdptr), .overflow(a_ovf), .underflow(a_unf));

  delayed_write_fifo_ptrs #(.DEPTH(DEPTH), .WRITE_DELAY(WD_B), .ALMOST_FULL_MARGIN(0),
                            .ALMOST_EMPTY_MARGIN(AEM_B)) dut_b (
    .clock(clk), .rst(b_rst), .wrreq(b_wrreq), .full(b_full), .rdreq(b_rdreq),
    .empty(b_empty), .almost_empty(b_aempty), .usedw(b_usedw), .wrptr(b_wrptr),
    .rdptr(b_rdptr), .overflow(b_ovf), .underflow(b_unf));

  // Reference model: integer occupancy, modulo pointers, and queues standing in for the delays.
  int m_occ[2], m_wp[2], m_rp[2];
  bit m_af[2], m_ovf[2], m_unf[2];
  bit m_wq[2][$];
  bit m_fq[2][$];

  task automatic model_step(input int k, input bit r, input bit w, input bit rd);
    int wd;
    int thr;
    bit wdel, wacc, racc;
    wd  = (k == 0) ? WD_A : WD_B;
    thr = DEPTH - 2 * wd;
    if (r) begin
      m_occ[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
      m_af[k] = 1'b1; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
      m_wq[k].delete(); m_fq[k].delete();
      for (int i = 0; i < wd; i++) begin
        m_wq[k].push_back(1'b0);
        m_fq[k].push_back(1'b1);
      end
    end else begin
      if (wd == 0) wdel = w;
      else begin
        wdel = m_wq[k].pop_front();
        m_wq[k].push_back(w);
        void'(m_fq[k].pop_front());
        m_fq[k].push_back(m_af[k]);
      end
      wacc = wdel && (m_occ[k] < DEPTH);
      racc = rd && (m_occ[k] > 0);
      if (wdel && !wacc) m_ovf[k] = 1'b1;
      if (rd && !racc)   m_unf[k] = 1'b1;
      m_occ[k] = m_occ[k] + int'(wacc) - int'(racc);
      if (wacc) m_wp[k] = (m_wp[k] + 1) % DEPTH;
      if (racc) m_rp[k] = (m_rp[k] + 1) % DEPTH;
      m_af[k] = (m_occ[k] >= thr);
    end
  endtask

  function automatic bit m_full(input int k);
    if (k == 0) return m_fq[0][0];
    return m_af[1];
  endfunction

  always @(posedge clk) begin
    model_step(0, a_rst, a_wrreq, a_rdreq);
    model_step(1, b_rst, b_wrreq, b_rdreq);
  end

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b, expected 1", a_empty); end
      checks++; if (a_usedw !== 5'd0) begin errors++; $display("FAIL rst_usedw: got %0d, expected 0", a_usedw); end
      checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL rst_full: got %b, expected 1", a_full); end
    end
    a_rst = 1'b0; b_rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_full !== (i < 3)) begin errors++; $display("FAIL rst_full_release_%0d: got %b, expected %b", i, a_full, (i < 3)); end
      if (i == 1) begin
        checks++; if (b_full !== 1'b0) begin errors++; $display("FAIL rst_full_b: got %b, expected 0", b_full); end
      end
    end
    checks++;
    if (a_aempty !== 1'b1 || a_wrptr !== 4'd0 || a_rdptr !== 4'd0 || a_ovf !== 1'b0 || a_unf !== 1'b0) begin
      errors++; $display("FAIL rst_misc: got aempty=%b wp=%0d rp=%0d ovf=%b unf=%b, expected 1 0 0 0 0",
                         a_aempty, a_wrptr, a_rdptr, a_ovf, a_unf);
    end
  endtask

  task automatic test_write_latency();
    int exp;
    a_wrreq = 1'b1;
    @(negedge clk);
    a_wrreq = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) @(negedge clk);
      exp = (i == 3) ? 1 : 0;
      checks++; if (a_usedw !== 5'(exp)) begin errors++; $display("FAIL lat_usedw_%0d: got %0d, expected %0d", i, a_usedw, exp); end
      checks++; if (a_empty !== (exp == 0)) begin errors++; $display("FAIL lat_empty_%0d: got %b, expected %b", i, a_empty, exp == 0); end
      checks++; if (a_wrptr !== 4'(exp)) begin errors++; $display("FAIL lat_wrptr_%0d: got %0d, expected %0d", i, a_wrptr, exp); end
    end
    a_rdreq = 1'b1;
    @(negedge clk);
    a_rdreq = 1'b0;
    checks++; if (a_usedw !== 5'd0 || a_rdptr !== 4'd1 || a_empty !== 1'b1) begin
      errors++; $display("FAIL lat_pop: got usedw=%0d rp=%0d empty=%b, expected 0 1 1", a_usedw, a_rdptr, a_empty);
    end
  endtask

  task automatic test_back_to_back();
    int c12, cf;
    c12 = -1; cf = -1;
    a_rst = 1'b1; @(negedge clk); a_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL bp_start_full: got %b, expected 0", a_full); end
    for (int n = 0; n < 40; n++) begin
      a_wrreq = !a_full;
      @(negedge clk);
      checks++; if (a_usedw !== 5'(m_occ[0])) begin errors++; $display("FAIL bp_usedw_%0d: got %0d, expected %0d", n, a_usedw, m_occ[0]); end
      if (a_usedw == 5'd12 && c12 < 0) c12 = n;
      if (a_full === 1'b1 && cf < 0) cf = n;
      if (cf >= 0 && n >= cf + 4) break;
    end
    a_wrreq = 1'b0;
    checks++; if (cf < 0 || c12 < 0) begin errors++; $display("FAIL bp_full_seen: got c12=%0d cf=%0d, expected both >=0", c12, cf); end
    checks++; if (cf - c12 != 2) begin errors++; $display("FAIL bp_af_at_12: got lag %0d, expected 2", cf - c12); end
    checks++; if (a_usedw > 5'd16 || a_usedw !== 5'd16) begin errors++; $display("FAIL bp_final_usedw: got %0d, expected 16", a_usedw); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b, expected 0", a_ovf); end
  endtask

  task automatic test_wrap();
    bit wrap_w, wrap_r;
    logic [3:0] pw, pr;
    wrap_w = 1'b0; wrap_r = 1'b0;
    b_rst = 1'b1; @(negedge clk); b_rst = 1'b0;
    b_wrreq = 1'b1; repeat (6) @(negedge clk);
    b_wrreq = 1'b0; b_rdreq = 1'b1; repeat (6) @(negedge clk);
    b_rdreq = 1'b0; b_wrreq = 1'b1; repeat (8) @(negedge clk);
    checks++; if (b_usedw !== 5'd8 || b_wrptr !== 4'd14 || b_rdptr !== 4'd6) begin
      errors++; $display("FAIL wrap_prefill: got usedw=%0d wp=%0d rp=%0d, expected 8 14 6", b_usedw, b_wrptr, b_rdptr);
    end
    b_rdreq = 1'b1;
    for (int n = 0; n < 20; n++) begin
      pw = b_wrptr; pr = b_rdptr;
      @(negedge clk);
      checks++; if (b_usedw !== 5'd8) begin errors++; $display("FAIL wrap_usedw_%0d: got %0d, expected 8", n, b_usedw); end
      checks++; if (4'(b_wrptr - b_rdptr) !== 4'd8) begin errors++; $display("FAIL wrap_diff_%0d: got %0d, expected 8", n, 4'(b_wrptr - b_rdptr)); end
      if (pw == 4'd15 && b_wrptr == 4'd0) wrap_w = 1'b1;
      if (pr == 4'd15 && b_rdptr == 4'd0) wrap_r = 1'b1;
    end
    b_wrreq = 1'b0; b_rdreq = 1'b0;
    checks++; if (!wrap_w || !wrap_r) begin errors++; $display("FAIL wrap_seen: got w=%b r=%b, expected 1 1", wrap_w, wrap_r); end
    checks++; if (b_wrptr !== 4'd2 || b_rdptr !== 4'd10) begin errors++; $display("FAIL wrap_final: got wp=%0d rp=%0d, expected 2 10", b_wrptr, b_rdptr); end
  endtask

  task automatic test_errors();
    b_rst = 1'b1; @(negedge clk); b_rst = 1'b0;
    b_wrreq = 1'b1; b_rdreq = 1'b1; @(negedge clk);
    b_wrreq = 1'b0; b_rdreq = 1'b0;
    checks++; if (b_usedw !== 5'd1 || b_wrptr !== 4'd1 || b_rdptr !== 4'd0) begin
      errors++; $display("FAIL err_simul_empty: got usedw=%0d wp=%0d rp=%0d, expected 1 1 0", b_usedw, b_wrptr, b_rdptr);
    end
    checks++; if (b_unf !== FLAGS) begin errors++; $display("FAIL err_unf_simul: got %b, expected %b", b_unf, FLAGS); end
    b_rdreq = 1'b1; @(negedge clk);
    b_rdreq = 1'b1; @(negedge clk);
    b_rdreq = 1'b0; @(negedge clk);
    checks++; if (b_usedw !== 5'd0 || b_empty !== 1'b1 || b_rdptr !== 4'd1) begin
      errors++; $display("FAIL err_rd_empty: got usedw=%0d empty=%b rp=%0d, expected 0 1 1", b_usedw, b_empty, b_rdptr);
    end
    checks++; if (b_unf !== FLAGS) begin errors++; $display("FAIL err_unf_sticky: got %b, expected %b", b_unf, FLAGS); end
    checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL err_ovf_clear: got %b, expected 0", b_ovf); end
    b_wrreq = 1'b1; repeat (16) @(negedge clk);
    checks++; if (b_usedw !== 5'd16 || b_full !== 1'b1) begin errors++; $display("FAIL err_fill: got usedw=%0d full=%b, expected 16 1", b_usedw, b_full); end
    @(negedge clk);
    checks++; if (b_usedw !== 5'd16 || b_wrptr !== 4'd1) begin errors++; $display("FAIL err_drop: got usedw=%0d wp=%0d, expected 16 1", b_usedw, b_wrptr); end
    checks++; if (b_ovf !== FLAGS) begin errors++; $display("FAIL err_ovf_set: got %b, expected %b", b_ovf, FLAGS); end
    b_rdreq = 1'b1; @(negedge clk);
    b_wrreq = 1'b0; b_rdreq = 1'b0;
    checks++; if (b_usedw !== 5'd15 || b_wrptr !== 4'd1 || b_rdptr !== 4'd2) begin
      errors++; $display("FAIL err_simul_full: got usedw=%0d wp=%0d rp=%0d, expected 15 1 2", b_usedw, b_wrptr, b_rdptr);
    end
    @(negedge clk);
    checks++; if (b_ovf !== FLAGS || b_unf !== FLAGS) begin errors++; $display("FAIL err_sticky: got ovf=%b unf=%b, expected %b", b_ovf, b_unf, FLAGS); end
    b_rst = 1'b1; @(negedge clk); b_rst = 1'b0;
    checks++; if (b_ovf !== 1'b0 || b_unf !== 1'b0) begin errors++; $display("FAIL err_rst_clear: got ovf=%b unf=%b, expected 0 0", b_ovf, b_unf); end
  endtask

  task automatic test_mid_reset();
    a_rst = 1'b1; b_rst = 1'b1; @(negedge clk); a_rst = 1'b0; b_rst = 1'b0;
    a_wrreq = 1'b1; b_wrreq = 1'b1; repeat (5) @(negedge clk);
    a_wrreq = 1'b0; b_wrreq = 1'b0; repeat (2) @(negedge clk);
    checks++; if (a_usedw !== 5'd5 || b_usedw !== 5'd5) begin errors++; $display("FAIL mid_fill: got a=%0d b=%0d, expected 5 5", a_usedw, b_usedw); end
    a_wrreq = 1'b1; @(negedge clk);
    a_wrreq = 1'b0; a_rst = 1'b1; b_rst = 1'b1; @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    checks++; if (a_usedw !== 5'd0 || a_empty !== 1'b1 || a_wrptr !== 4'd0 || a_rdptr !== 4'd0) begin
      errors++; $display("FAIL mid_a_state: got usedw=%0d empty=%b wp=%0d rp=%0d, expected 0 1 0 0", a_usedw, a_empty, a_wrptr, a_rdptr);
    end
    checks++; if (b_usedw !== 5'd0 || b_empty !== 1'b1) begin errors++; $display("FAIL mid_b_state: got usedw=%0d empty=%b, expected 0 1", b_usedw, b_empty); end
    checks++; if (b_full !== 1'b1 || a_full !== 1'b1) begin errors++; $display("FAIL mid_af_forced: got b=%b a=%b, expected 1 1", b_full, a_full); end
    @(negedge clk);
    checks++; if (b_full !== 1'b0) begin errors++; $display("FAIL mid_af_release: got %b, expected 0", b_full); end
    repeat (3) @(negedge clk);
    checks++; if (a_usedw !== 5'd0) begin errors++; $display("FAIL mid_inflight_dropped: got %0d, expected 0", a_usedw); end
  endtask

  task automatic test_random();
    int au, aw, ar, af, ae, aa, ao, ad;
    for (int n = 0; n < 600; n++) begin
      bit hi;
      hi = ((n / 60) % 2) == 1;
      a_rst   = ($urandom_range(0, 99) == 0);
      b_rst   = ($urandom_range(0, 99) == 0);
      a_wrreq = ($urandom_range(0, 99) < (hi ? 80 : 25));
      a_rdreq = ($urandom_range(0, 99) < (hi ? 25 : 80));
      b_wrreq = ($urandom_range(0, 99) < (hi ? 75 : 30));
      b_rdreq = ($urandom_range(0, 99) < (hi ? 30 : 75));
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        au = (k == 0) ? int'(a_usedw) : int'(b_usedw);
        aw = (k == 0) ? int'(a_wrptr) : int'(b_wrptr);
        ar = (k == 0) ? int'(a_rdptr) : int'(b_rdptr);
        af = (k == 0) ? int'(a_full) : int'(b_full);
        ae = (k == 0) ? int'(a_empty) : int'(b_empty);
        aa = (k == 0) ? int'(a_aempty) : int'(b_aempty);
        ao = (k == 0) ? int'(a_ovf) : int'(b_ovf);
        ad = (k == 0) ? int'(a_unf) : int'(b_unf);
        checks++; if (au != m_occ[k]) begin errors++; $display("FAIL rnd_usedw[%0d]@%0d: got %0d, expected %0d", k, n, au, m_occ[k]); end
        checks++; if (aw != m_wp[k] || ar != m_rp[k]) begin errors++; $display("FAIL rnd_ptrs[%0d]@%0d: got %0d/%0d, expected %0d/%0d", k, n, aw, ar, m_wp[k], m_rp[k]); end
        checks++; if (af != int'(m_full(k))) begin errors++; $display("FAIL rnd_full[%0d]@%0d: got %0d, expected %0d", k, n, af, m_full(k)); end
        checks++; if (ae != int'(m_occ[k] == 0)) begin errors++; $display("FAIL rnd_empty[%0d]@%0d: got %0d, expected %0d", k, n, ae, m_occ[k] == 0); end
        checks++; if (aa != int'(m_occ[k] <= ((k == 0) ? AEM_A : AEM_B))) begin errors++; $display("FAIL rnd_aempty[%0d]@%0d: got %0d", k, n, aa); end
        checks++; if (ao != int'(FLAGS & m_ovf[k]) || ad != int'(FLAGS & m_unf[k])) begin
          errors++; $display("FAIL rnd_flags[%0d]@%0d: got %0d/%0d, expected %0d/%0d", k, n, ao, ad, FLAGS & m_ovf[k], FLAGS & m_unf[k]);
        end
      end
    end
    a_rst = 1'b0; b_rst = 1'b0; a_wrreq = 1'b0; a_rdreq = 1'b0; b_wrreq = 1'b0; b_rdreq = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_latency();
    test_back_to_back();
    test_wrap();
    test_errors();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delayed_write_fifo_ptrs.md
# delayed_write_fifo_ptrs

Pointer-and-status engine for a dataless (zero-width) show-ahead FIFO whose write request reaches the counters through a fixed flip-flop delay, and whose almost-full back-pressure returns to the writer through an equal delay. It sits between a pipelined producer and a consumer, tracking occupancy, read/write pointers, full/empty status and sticky error flags. Data storage, when needed, is an external RAM addressed by `wrptr`/`rdptr`.

## Interface
- `DEPTH`, 16: capacity in entries; power of two, ≥ 2.
- `WRITE_DELAY`, 0: number of register stages on the write-request path and on the full return path.
- `ALMOST_FULL_MARGIN`, 0: free-entry margin before `full` asserts, with `WRITE_DELAY` = 0.
- `ALMOST_EMPTY_MARGIN`, 0: `almost_empty` threshold.
- `LOG_DEPTH`, derived: `$clog2(DEPTH)`; it must not be overridden.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: sole clock, rising edge.
- `rst` in 1: synchronous reset, active high.
- `wrreq` in 1: write request, pre-delay.
- `full` out 1: delayed almost-full; the writer stops when high.
- `rdreq` in 1: read/pop request.
- `empty` out 1: no entries.
- `almost_empty` out 1: occupancy ≤ `ALMOST_EMPTY_MARGIN`.
- `usedw` out `LOG_DEPTH+1`: occupancy, 0..`DEPTH`.
- `wrptr` out `LOG_DEPTH`: next write slot.
- `rdptr` out `LOG_DEPTH`: current head slot.
- `overflow` out 1: sticky overflow flag.
- `underflow` out 1: sticky underflow flag.

## Operation
- Effective margin: `AF_INT = ALMOST_FULL_MARGIN + 2*WRITE_DELAY`, which covers the round trip of the delay in each direction. Elaboration `$error` if `AF_INT >= DEPTH`.
- Write path: `wrreq` passes through `WRITE_DELAY` reset-to-0 registers to produce `wr_d`. When `WRITE_DELAY` = 0, `wr_d` is a direct wire.
- Counter (on `wr_d`/`rdreq`):
  - Write accepted when `wr_d` and occupancy < `DEPTH`. Read accepted when `rdreq` and occupancy > 0.
  - Accepted write: `wrptr`+1, wrapping modulo `DEPTH`. Accepted read: `rdptr`+1, wrapping modulo `DEPTH`.
  - `usedw` is incremented, decremented, or left unchanged when both a write and a read are accepted in the same cycle.
  - A write when full is dropped and does not advance `wrptr`; it sets `overflow`. A read when empty is ignored; it sets `underflow`.
  - A simultaneous write and read at occupancy `DEPTH` accepts the read only, and the write sets `overflow`.
  - A simultaneous write and read at occupancy 0 accepts the write only, and the read sets `underflow`.
- `empty`, `almost_empty` and internal `af_int` are registered from the next-state occupancy. `af_int` = next-occupancy ≥ `DEPTH - AF_INT`.
- Full return path: `af_int` passes through `WRITE_DELAY` registers to produce `full`. These registers reset to 1.
- Reset values: `usedw`=0, `wrptr`=0, `rdptr`=0, `empty`=1, `almost_empty`=1, `af_int`=1, all `full` stages=1, write-delay stages=0, `overflow`=0, `underflow`=0.
- `af_int` is forced to 1 on the cycle after any cycle with `rst` high, including reset asserted mid-operation, which discards all contents.

## Timing
- `wrreq` sampled in cycle t is counted at the end of cycle t+`WRITE_DELAY`. `usedw`/`empty` reflect it in cycle t+`WRITE_DELAY`+1.
- `rdreq` in cycle t is reflected in `usedw`/`empty` at cycle t+1. Show-ahead: the head is at `rdptr` while `empty`=0.
- `af_int` changes one cycle after the occupancy crossing. `full` follows `af_int` `WRITE_DELAY` cycles later.
- After `rst` falls, `af_int` clears one cycle later if the FIFO is empty. `full` clears `WRITE_DELAY` cycles after that.

## Configuration
- `FIFO_PTRS_DEBUG_FLAGS_EN`: when defined, `overflow`/`underflow` are sticky registers as described in Operation, cleared only by `rst`.
- Undefined: both outputs are tied to 0 and no flag logic is built.
- Drop and ignore behaviour on overflow/underflow is identical in both builds.

## Test plan
- Reset: `DEPTH`=16, `WRITE_DELAY`=2. Hold `rst` 3 cycles → `empty`=1, `usedw`=0, `full`=1 during reset, `full`=0 three cycles after `rst` falls.
- Write latency: `WRITE_DELAY`=2, single `wrreq` pulse at cycle 10 → `usedw`=1 and `empty`=0 first at cycle 13, `wrptr`=1.
- Back-pressure: `DEPTH`=16, `WRITE_DELAY`=2, `ALMOST_FULL_MARGIN`=0. Write every cycle until `full`, then stop → final `usedw` ≤ 16, `overflow`=0, `af_int` rises at occupancy 12.
- Wrap and simultaneous: `WRITE_DELAY`=0. Fill to 8, then write and read together for 20 cycles → `usedw` stays at 8, and `wrptr`/`rdptr` wrap from 15 to 0 with a constant difference of 8.
- Errors (`FIFO_PTRS_DEBUG_FLAGS_EN` defined): `rdreq` at occupancy 0 → `underflow`=1 sticky, `usedw` stays 0. Force a write at occupancy 16 → `overflow`=1 sticky, `usedw` stays 16. `rst` clears both flags.
- Mid-operation reset: at occupancy 5, assert `rst` one cycle → `usedw`=0, `empty`=1, pointers 0, `af_int`=1 on the next cycle.
